// File: rtl/data_mem_mmio.sv
// M-stage data memory for the pipelined MIPS core: word RAM plus memory-mapped
// LED, cycle counter, compare timer with interrupt, and a byte TX FIFO.
module data_mem_mmio #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Address decode
  logic          ioSel;
  logic [7:0]    ioOff;
  logic [AW-1:0] ramIdx;
  logic          ramWe, ioWe;
  logic          wrLed, wrCycle, wrTx, wrStatus, wrCmp, wrCtl;
  logic          unusedAddr;

  assign ioSel      = (Addr[31:16] == 16'hFFFF);
  assign ioOff      = Addr[7:0];
  assign ramIdx     = Addr[AW+1:2];
  assign unusedAddr = ^{Addr[15:8], Addr[1:0]};

  assign ramWe    = MemWrite & ~ioSel;
  assign ioWe     = MemWrite & ioSel;
  assign wrLed    = ioWe && (ioOff == 8'h00);
  assign wrCycle  = ioWe && (ioOff == 8'h04);
  assign wrTx     = ioWe && (ioOff == 8'h08);
  assign wrStatus = ioWe && (ioOff == 8'h0C);
  assign wrCmp    = ioWe && (ioOff == 8'h10);
  assign wrCtl    = ioWe && (ioOff == 8'h14);

  // Data RAM: no reset, contents undefined until written
  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge CLK) begin
    if (ramWe) mem[ramIdx] <= WriteData;
  end

  // Cycle counter, LED, compare timer
  logic [31:0] cycle, timerCmp;
  logic        timerEn, irqFlag;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      led      <= '0;
      cycle    <= '0;
      timerCmp <= '0;
      timerEn  <= 1'b0;
      irqFlag  <= 1'b0;
    end else begin
      cycle <= wrCycle ? 32'd0 : cycle + 32'd1;
      if (wrLed) led <= WriteData[15:0];
      if (wrCmp) timerCmp <= WriteData;
      if (wrCtl) timerEn <= WriteData[0];
      // A match in the same cycle as a write-1-to-clear keeps the flag set
      if (timerEn && (cycle == timerCmp)) irqFlag <= 1'b1;
      else if (wrCtl && WriteData[1])     irqFlag <= 1'b0;
    end
  end

  assign irq = irqFlag;

  // TX FIFO. Handshake: a byte transfers on every rising edge where
  // tx_valid && tx_ready; tx_valid/tx_data depend only on registered state.
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic          overflow, fifoFull, pop, pushOk;

  assign fifoFull = (count == CW'(FIFO_DEPTH));
  assign tx_valid = (count != '0);
  assign tx_data  = fifoMem[rdPtr];
  assign pop      = tx_valid & tx_ready;
  assign pushOk   = wrTx & (~fifoFull | pop);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
    end else begin
      if (pushOk) begin
        fifoMem[wrPtr] <= WriteData[7:0];
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(pushOk) - CW'(pop);
      if (wrTx && !pushOk) overflow <= 1'b1;
      else if (wrStatus)   overflow <= 1'b0;
    end
  end

  // Read mux: depends only on Addr and current state, never on this cycle's store
  logic [3:0] countField;
  assign countField = 4'(count);

  always_comb begin
    ReadData = '0;
    if (!ioSel) begin
      ReadData = mem[ramIdx];
    end else begin
      case (ioOff)
        8'h00:   ReadData = {16'h0000, led};
        8'h04:   ReadData = cycle;
        8'h0C:   ReadData = {24'h0, countField, 1'b0, overflow, ~tx_valid, fifoFull};
        8'h10:   ReadData = timerCmp;
        8'h14:   ReadData = {30'h0, irqFlag, timerEn};
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboarded bench for data_mem_mmio: directed scenarios then random traffic,
// checked against a queue/array reference model of the memory map.
module tb_data_mem_mmio;

  localparam int MEM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        irq;

  data_mem_mmio #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .led(led),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [31:0] ramM [int];
  logic [15:0] ledM;
  logic [31:0] cycM, cmpM;
  logic        enM, flagM, ovfM;
  logic [7:0]  fifoM [$];
  bit          known = 0;

  // Scoreboard queues
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [17:0] stat_q [$];
  logic [7:0]  tx_q [$];

  function automatic logic [31:0] statusM();
    logic [31:0] s;
    s = '0;
    s[0]   = (fifoM.size() == FIFO_DEPTH);
    s[1]   = (fifoM.size() == 0);
    s[2]   = ovfM;
    s[7:4] = 4'(fifoM.size());
    return s;
  endfunction

  function automatic int ramKey(input logic [31:0] a);
    return int'((a / 4) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a[31:16] != 16'hFFFF) return ramM[ramKey(a)];
    case (a[7:0])
      8'h00:   return {16'h0, ledM};
      8'h04:   return cycM;
      8'h0C:   return statusM();
      8'h10:   return cmpM;
      8'h14:   return {30'h0, flagM, enM};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelStep(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic rdy, input logic rst);
    logic        full, popNow, setF, clr;
    logic [31:0] nextCyc;
    logic [7:0]  dropped;
    if (rst) begin
      ledM = '0; cycM = '0; cmpM = '0; enM = 0; flagM = 0; ovfM = 0;
      fifoM.delete();
      known = 1;
      return;
    end
    full    = (fifoM.size() == FIFO_DEPTH);
    popNow  = rdy && (fifoM.size() > 0);
    setF    = enM && (cycM == cmpM);
    clr     = 0;
    nextCyc = cycM + 1;
    if (popNow) dropped = fifoM.pop_front();
    if (we) begin
      if (a[31:16] != 16'hFFFF) ramM[ramKey(a)] = wd;
      else case (a[7:0])
        8'h00: ledM = wd[15:0];
        8'h04: nextCyc = 0;
        8'h08: if (!full || popNow) fifoM.push_back(wd[7:0]); else ovfM = 1;
        8'h0C: ovfM = 0;
        8'h10: cmpM = wd;
        8'h14: begin enM = wd[0]; clr = wd[1]; end
        default: ;
      endcase
    end
    cycM = nextCyc;
    if (setF) flagM = 1;
    else if (clr) flagM = 0;
  endtask

  // Driver: one bus cycle; expectations come from the model state before the edge
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input logic rst, input logic chk, input string nm);
    @(posedge CLK); #1;
    Reset = rst; MemWrite = we; Addr = a; WriteData = wd; tx_ready = rdy;
    if (known) stat_q.push_back({flagM, (fifoM.size() != 0), ledM});
    if (chk) begin
      exp_q.push_back(modelRead(a));
      name_q.push_back(nm);
    end
    if (known && rdy && !rst && fifoM.size() > 0) tx_q.push_back(fifoM[0]);
    modelStep(we, a, wd, rdy, rst);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    step(1'b1, a, wd, rdy, 1'b0, 1'b0, "");
  endtask

  task automatic rd(input logic [31:0] a, input string nm);
    step(1'b0, a, 32'h0, 1'b0, 1'b0, 1'b1, nm);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0, "");
  endtask

  // Monitor
  logic [17:0] s;
  logic [31:0] e;
  string       nmx;
  always @(negedge CLK) begin
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      checks += 3;
      if (led !== s[15:0]) begin
        failures++; $display("FAIL led: got %h want %h @%0t", led, s[15:0], $time);
      end
      if (tx_valid !== s[16]) begin
        failures++; $display("FAIL tx_valid: got %b want %b @%0t", tx_valid, s[16], $time);
      end
      if (irq !== s[17]) begin
        failures++; $display("FAIL irq: got %b want %b @%0t", irq, s[17], $time);
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nmx = name_q.pop_front();
      checks++;
      if (ReadData !== e) begin
        failures++;
        $display("FAIL read %s addr=%h: got %h want %h @%0t", nmx, Addr, ReadData, e, $time);
      end
    end
    if (tx_valid === 1'b1 && tx_ready && !Reset) begin
      checks++;
      if (tx_q.size() == 0) begin
        failures++; $display("FAIL tx_pop: unexpected byte %h @%0t", tx_data, $time);
      end else begin
        e[7:0] = tx_q.pop_front();
        if (tx_data !== e[7:0]) begin
          failures++; $display("FAIL tx_data: got %h want %h @%0t", tx_data, e[7:0], $time);
        end
      end
    end
  end

  localparam logic [31:0] IO = 32'hFFFF_0000;

  initial begin
    logic [31:0] ioOffs [9];
    logic [31:0] a, wd;
    int r;
    ioOffs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h40, 32'hFC};

    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "");
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "");
    rd(IO | 32'h0C, "status_reset");
    rd(IO | 32'h04, "cycle_reset");
    rd(IO | 32'h14, "ctl_reset");

    // RAM and aliasing
    wr(32'h10, 32'hDEADBEEF, 1'b0);
    rd(32'h10, "ram");
    rd(32'h10 + 4 * MEM_WORDS, "ram_alias");
    step(1'b1, 32'h14, 32'h0BADF00D, 1'b0, 1'b0, 1'b1, "ram_no_writethru");

    // LED and unmapped
    wr(IO, 32'h1234ABCD, 1'b0);
    rd(IO, "led");
    rd(IO | 32'h40, "unmapped");
    wr(IO | 32'h40, 32'hFFFFFFFF, 1'b0);
    rd(IO, "led_after_unmapped");

    // Timer
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "");
    wr(IO | 32'h10, 32'd20, 1'b0);
    wr(IO | 32'h14, 32'h1, 1'b0);
    idle(25, 1'b0);
    rd(IO | 32'h14, "ctl_flag");
    wr(IO | 32'h14, 32'h3, 1'b0);
    rd(IO | 32'h14, "ctl_cleared");
    wr(IO | 32'h04, 32'h5555, 1'b0);
    rd(IO | 32'h04, "cycle_zero");
    rd(IO | 32'h04, "cycle_one");

    // FIFO fill, overflow, handshake, drain
    for (int i = 0; i < 5; i++) wr(IO | 32'h08, 32'h41 + i, 1'b0);
    rd(IO | 32'h0C, "status_full");
    wr(IO | 32'h0C, 32'h0, 1'b0);
    rd(IO | 32'h0C, "status_ovf_clr");
    wr(IO | 32'h08, 32'h46, 1'b1);
    rd(IO | 32'h0C, "status_push_pop");
    idle(5, 1'b1);
    rd(IO | 32'h0C, "status_drained");

    // Reset mid-operation
    for (int i = 0; i < 3; i++) wr(IO | 32'h08, 32'h60 + i, 1'b0);
    wr(IO | 32'h10, cycM + 3, 1'b0);
    wr(IO | 32'h14, 32'h1, 1'b0);
    idle(4, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, "");
    rd(IO | 32'h0C, "status_after_reset");
    @(negedge CLK);
    checks++;
    if (tx_data !== 8'h00) begin
      failures++; $display("FAIL tx_data_reset: got %h want 00", tx_data);
    end

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      a = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom), 6'($urandom_range(0, 7)), 2'($urandom)};
      wd = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        step(1'b0, 32'h0, 32'h0, 1'($urandom), 1'b1, 1'b0, "");
      end else if (r <= 1) begin
        step(1'b1, a, wd, 1'($urandom), 1'b0, 1'b0, "");
      end else if (r <= 3) begin
        step(1'b0, a, 32'h0, 1'($urandom), 1'b0, ramM.exists(ramKey(a)), "ram_rand");
      end else if (r == 4) begin
        step(1'b1, IO | 32'h08, wd, ($urandom_range(0, 2) == 0), 1'b0, 1'b0, "");
      end else if (r == 5) begin
        step(1'b0, IO | ioOffs[$urandom_range(0, 8)], 32'h0, 1'($urandom), 1'b0, 1'b1, "io_rand");
      end else if (r == 6) begin
        a = IO | ioOffs[$urandom_range(0, 8)];
        if (a[7:0] == 8'h10) wd = cycM + $urandom_range(1, 20);
        if (a[7:0] == 8'h14) wd = $urandom_range(0, 3);
        if (a[7:0] == 8'h04 && $urandom_range(0, 3) != 0) a = IO;
        step(1'b1, a, wd, 1'($urandom), 1'b0, 1'b0, "");
      end else begin
        step(1'b0, a, 32'h0, 1'($urandom), 1'b0, 1'b0, "");
      end
    end

    idle(2, 1'b0);
    @(negedge CLK);
    #1;
    checks++;
    if (tx_q.size() != 0) begin
      failures++; $display("FAIL tx_pending: got %0d bytes left want 0", tx_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Memory-stage consumer for the pipelined MIPS core: data RAM plus memory-mapped I/O on the core's M-stage data bus (MemWriteM, AluOutM, WriteDataM, ReadDataM).
- Reads are combinational so ReadDataM is valid in the same M cycle; writes commit at the clock edge.
- I/O space provides an LED register, a free-running cycle counter, a compare timer with interrupt, and a byte TX FIFO with a valid/ready handshake to an external serializer.

Parameters:
MEM_WORDS, 64, data RAM depth in 32-bit words (power of 2)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
MemWrite  input  1  store strobe from M stage
Addr  input  32  byte address (AluOutM)
WriteData  input  32  store data (WriteDataM)
ReadData  output  32  load data (ReadDataM), combinational
led  output  16  LED register
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  serializer accepts head this cycle
irq  output  1  timer interrupt flag

Behaviour:
- Decode:
  - Addr[31:16]==16'hFFFF selects I/O space, offset Addr[7:0]; anything else selects RAM.
  - RAM word index = Addr[log2(MEM_WORDS)+1:2]; upper bits ignored (aliasing); Addr[1:0] ignored (word access only).
- RAM: write on posedge when MemWrite and RAM selected. Not reset; contents X until written.
- I/O map (unmapped offsets read 0, writes ignored):
  - 0x00 LED: RW; led <= WriteData[15:0]; reads zero-extended.
  - 0x04 CYCLE: RO value; any write sets next value to 0. Otherwise +1 every cycle, wraps 32'hFFFFFFFF -> 0.
  - 0x08 TX_DATA: write pushes WriteData[7:0]; reads 0.
  - 0x0C TX_STATUS: RO; bit0 full, bit1 empty, bit2 sticky overflow, bits[7:4] count; other bits 0. Any write clears overflow.
  - 0x10 TIMER_CMP: RW 32-bit.
  - 0x14 TIMER_CTL: bit0 enable (RW), bit1 irq flag. Writing 1 to bit1 clears the flag; writing 0 leaves it unchanged.
- Timer: when enable=1 and CYCLE (current registered value) == TIMER_CMP, flag <= 1. irq = flag (registered). Set and clear in the same cycle: set wins.
- TX FIFO:
  - Circular buffer with read/write pointers and count (log2(FIFO_DEPTH)+1 bits).
  - pop = tx_valid & tx_ready; head advances at the edge.
  - tx_data = head entry; tx_valid = count!=0. Both registered-state-derived; no combinational path from tx_ready.
  - push accepted when count<FIFO_DEPTH, or when count==FIFO_DEPTH and pop occurs the same cycle (count unchanged, pointers both advance).
  - Push refused when full without a pop: byte dropped, overflow <= 1.
  - Simultaneous push+pop when non-full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (synchronous, priority over all writes):
  - led=0, CYCLE=0, TIMER_CMP=0, enable=0, irq=0, overflow=0.
  - FIFO empty (tx_valid=0, tx_data=0 after reset since storage is reset).
  - Reset mid-transfer discards FIFO contents; tx_ready is ignored during reset.
- ReadData is a pure function of Addr and current state; MemWrite does not affect ReadData in the same cycle (no write-through).

Test Plan:
- RAM: store 0xDEADBEEF to 0x10, then load 0x10 -> ReadData=0xDEADBEEF. Load 0x10+4*MEM_WORDS -> same value (alias).
- LED/unmapped: store 0x1234ABCD to 0xFFFF0000 -> led=0xABCD, read 0x0000ABCD. Read 0xFFFF0040 -> 0. Store there -> no state change.
- Cycle/timer: Reset, CMP=20, CTL=1 -> irq rises the cycle after CYCLE==20. Write CTL=0x3 -> irq stays 0 only once the cycle is past the match. Write CYCLE -> next read 0, then 1.
- FIFO fill: tx_ready=0, push 0x41..0x45 -> status full=1, count=4, overflow=1, tx_data=0x41. Write status -> overflow=0.
- FIFO handshake: full FIFO, tx_ready=1 plus push 0x46 same cycle -> count stays 4, order 0x42,0x43,0x44,0x46, overflow=0. Drain -> empty=1, tx_valid=0.
- Reset mid-operation: Reset with 3 bytes queued and irq=1 -> next cycle tx_valid=0, count=0, irq=0, led=0.
